snake_body_engine: RTL and testbench

Parametrised per-snake movement engine. It holds one snake's body as a ring buffer of segment directions, plus head and tail coordinates. It executes one accepted step per handshake: head advance, optional growth, wall or wrap handling, and a multi-cycle self-collision walk over the body. Each player has one instance; it sits between the game-tick/input logic and the map renderer, which reads body segments through a random-access read port.

---
 rtl/snake_body_engine_if.sv | 15 +
 rtl/snake_body_engine.sv | 218 +++++++++++++++++++++
 tb/tb_snake_body_engine.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/snake_body_engine_if.sv
// Step handshake between the game-tick/input logic (master) and one
// snake_body_engine (slave). A step transfers when step_valid && step_ready.
//   step_valid : master has a step to apply
//   step_ready : engine is idle and no collision flag is set
//   step_dir   : NONE=0 UP=1 RIGHT=2 DOWN=3 LEFT=4, 5..7 read as NONE
//   step_grow  : grow by one cell on this step
interface snake_body_engine_if;
  logic       step_valid;
  logic       step_ready;
  logic [2:0] step_dir;
  logic       step_grow;

  modport master (output step_valid, step_dir, step_grow, input step_ready);
  modport slave  (input step_valid, step_dir, step_grow, output step_ready);
endinterface

// File: rtl/snake_body_engine.sv
// Per-snake movement engine: the body is a ring of segment directions
// (tail towards head) plus registered head and tail coordinates.
// Each accepted step resolves the direction, advances the head (wall or
// wrap), walks the body one cell per cycle looking for a self-hit, then
// commits the move/growth and pulses done.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   init              synchronous restart, overrides everything
//   step              step handshake (slave modport)
//   head_x/head_y     head cell,  tail_x/tail_y tail cell
//   length            length in cells, cur_dir last applied direction
//   done              one-cycle pulse when a step completes
//   hit_wall/hit_self sticky collision flags
//   rd_idx -> rd_dir  combinational segment read relative to the tail
module snake_body_engine #(
  parameter int MAX_LEN   = 15,
  parameter int LEN_W     = 4,
  parameter int MAP_W     = 64,
  parameter int X_W       = 6,
  parameter int MAP_H     = 48,
  parameter int Y_W       = 6,
  parameter int START_LEN = 3,
  parameter int START_X   = 61,
  parameter int START_Y   = 43,
  parameter int WRAP      = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               init,
  snake_body_engine_if.slave step,
  output logic [X_W-1:0]     head_x,
  output logic [Y_W-1:0]     head_y,
  output logic [X_W-1:0]     tail_x,
  output logic [Y_W-1:0]     tail_y,
  output logic [LEN_W-1:0]   length,
  output logic [2:0]         cur_dir,
  output logic               done,
  output logic               hit_wall,
  output logic               hit_self,
  input  logic [LEN_W-1:0]   rd_idx,
  output logic [2:0]         rd_dir
);

  localparam int DEPTH = MAX_LEN - 1;

  localparam logic [2:0] DIR_NONE  = 3'd0;
  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_RIGHT = 3'd2;
  localparam logic [2:0] DIR_DOWN  = 3'd3;
  localparam logic [2:0] DIR_LEFT  = 3'd4;

  typedef enum logic [1:0] {IDLE, CALC, CHECK, COMMIT} state_t;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } xy_t;

  state_t             state, state_nx;
  logic [2:0]         ring [DEPTH];
  logic [LEN_W-1:0]   tail_ptr;
  logic [LEN_W-1:0]   cnt;
  logic [2:0]         cap_dir, res_dir, res_dir_c;
  logic               cap_grow, grow_eff;
  logic [X_W-1:0]     new_x, cur_x;
  logic [Y_W-1:0]     new_y, cur_y;
  logic               pend_wall, pend_self;
  logic               calc_wall, ready;
  xy_t                calc_xy, cur_xy, tail_xy;

  // Neighbour cell in direction d, wrapping at the map edges.
  function automatic xy_t step_xy(input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                                  input logic [2:0] d);
    xy_t r;
    r.x = x;
    r.y = y;
    case (d)
      DIR_UP:    r.y = (y == '0) ? Y_W'(MAP_H - 1) : y - Y_W'(1);
      DIR_DOWN:  r.y = (int'(y) >= MAP_H - 1) ? '0 : y + Y_W'(1);
      DIR_RIGHT: r.x = (int'(x) >= MAP_W - 1) ? '0 : x + X_W'(1);
      DIR_LEFT:  r.x = (x == '0) ? X_W'(MAP_W - 1) : x - X_W'(1);
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic at_edge(input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                                   input logic [2:0] d);
    logic e;
    e = 1'b0;
    case (d)
      DIR_UP:    e = (y == '0);
      DIR_DOWN:  e = (int'(y) >= MAP_H - 1);
      DIR_RIGHT: e = (int'(x) >= MAP_W - 1);
      DIR_LEFT:  e = (x == '0);
      default: ;
    endcase
    return e;
  endfunction

  // base + off modulo DEPTH; both operands keep the sum below 2*DEPTH.
  function automatic logic [LEN_W-1:0] ring_idx(input logic [LEN_W-1:0] base,
                                                input logic [LEN_W-1:0] off);
    logic [LEN_W:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (int'(s) >= DEPTH) s = s - (LEN_W+1)'(DEPTH);
    return s[LEN_W-1:0];
  endfunction

  function automatic logic [2:0] resolve(input logic [2:0] d, input logic [2:0] c);
    logic [2:0] r;
    r = d;
    if (d == DIR_NONE || d > DIR_LEFT) r = c;
    else if ((d == DIR_UP    && c == DIR_DOWN)  || (d == DIR_DOWN  && c == DIR_UP) ||
             (d == DIR_RIGHT && c == DIR_LEFT)  || (d == DIR_LEFT  && c == DIR_RIGHT))
      r = c;
    return r;
  endfunction

  assign ready           = (state == IDLE) && !hit_wall && !hit_self;
  assign step.step_ready = ready;

  assign res_dir_c = resolve(cap_dir, cur_dir);
  assign calc_xy   = step_xy(head_x, head_y, res_dir_c);
  assign calc_wall = (WRAP == 0) && at_edge(head_x, head_y, res_dir_c);
  assign cur_xy    = step_xy(cur_x, cur_y, ring[ring_idx(tail_ptr, cnt)]);
  assign tail_xy   = step_xy(tail_x, tail_y, ring[tail_ptr]);

  always_comb begin
    rd_dir = DIR_NONE;
    if (rd_idx < length - LEN_W'(1)) rd_dir = ring[ring_idx(tail_ptr, rd_idx)];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (step.step_valid && ready) state_nx = CALC;
      CALC:   state_nx = calc_wall ? COMMIT : CHECK;
      CHECK:  if (cnt == length - LEN_W'(1)) state_nx = COMMIT;
      COMMIT: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (init) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_x <= X_W'(START_X);  head_y <= Y_W'(START_Y);
      tail_x <= X_W'(START_X);  tail_y <= Y_W'(START_Y + START_LEN - 1);
      length <= LEN_W'(START_LEN);
      cur_dir <= DIR_UP;  ring <= '{default: DIR_UP};  tail_ptr <= '0;
      done <= 1'b0;  hit_wall <= 1'b0;  hit_self <= 1'b0;
      cap_dir <= DIR_NONE;  cap_grow <= 1'b0;  res_dir <= DIR_UP;  grow_eff <= 1'b0;
      new_x <= '0;  new_y <= '0;  cur_x <= '0;  cur_y <= '0;  cnt <= '0;
      pend_wall <= 1'b0;  pend_self <= 1'b0;
    end else if (init) begin
      head_x <= X_W'(START_X);  head_y <= Y_W'(START_Y);
      tail_x <= X_W'(START_X);  tail_y <= Y_W'(START_Y + START_LEN - 1);
      length <= LEN_W'(START_LEN);
      cur_dir <= DIR_UP;  ring <= '{default: DIR_UP};  tail_ptr <= '0;
      done <= 1'b0;  hit_wall <= 1'b0;  hit_self <= 1'b0;
      pend_wall <= 1'b0;  pend_self <= 1'b0;  cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (step.step_valid && ready) begin
          cap_dir  <= step.step_dir;
          cap_grow <= step.step_grow;
        end
        CALC: begin
          res_dir   <= res_dir_c;
          new_x     <= calc_xy.x;
          new_y     <= calc_xy.y;
          grow_eff  <= cap_grow && (int'(length) < MAX_LEN);
          pend_wall <= calc_wall;
          pend_self <= 1'b0;
          cnt       <= '0;
          cur_x     <= tail_x;
          cur_y     <= tail_y;
        end
        CHECK: begin
          // Cell 0 is the tail, which vacates on a plain move.
          if (cur_x == new_x && cur_y == new_y && (cnt != '0 || grow_eff))
            pend_self <= 1'b1;
          cur_x <= cur_xy.x;
          cur_y <= cur_xy.y;
          cnt   <= cnt + LEN_W'(1);
        end
        COMMIT: begin
          done <= 1'b1;
          if (pend_wall) hit_wall <= 1'b1;
          else if (pend_self) hit_self <= 1'b1;
          else begin
            // At full length the write slot equals the tail slot; the tail
            // move below still sees the old segment.
            ring[ring_idx(tail_ptr, length - LEN_W'(1))] <= res_dir;
            head_x  <= new_x;
            head_y  <= new_y;
            cur_dir <= res_dir;
            if (grow_eff) length <= length + LEN_W'(1);
            else begin
              tail_x   <= tail_xy.x;
              tail_y   <= tail_xy.y;
              tail_ptr <= ring_idx(tail_ptr, LEN_W'(1));
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_body_engine.sv
module tb_snake_body_engine;

  localparam int NONE = 0, UP = 1, RT = 2, DN = 3, LT = 4;

  typedef struct {
    int pre_init;
    int dir, grow;
    int hx, hy, tx, ty, len, cdir, wall, slf, lat;
    int rd0, rd1, rdtop;
  } vec_t;

  typedef struct {
    vec_t v;
    int   acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  logic [5:0] head_x, tail_x, head_y, tail_y, w_head_x, w_tail_x, w_head_y, w_tail_y;
  logic [3:0] length, w_length, rd_idx, w_rd_idx;
  logic [2:0] cur_dir, w_cur_dir, rd_dir, w_rd_dir;
  logic       done, hit_wall, hit_self, w_done, w_hit_wall, w_hit_self;

  exp_t sb[$];
  vec_t tbl[$];

  snake_body_engine_if sif ();
  snake_body_engine_if wif ();

  snake_body_engine #(.WRAP(0)) dut (
    .clk(clk), .rst_n(rst_n), .init(init), .step(sif),
    .head_x(head_x), .head_y(head_y), .tail_x(tail_x), .tail_y(tail_y),
    .length(length), .cur_dir(cur_dir), .done(done),
    .hit_wall(hit_wall), .hit_self(hit_self), .rd_idx(rd_idx), .rd_dir(rd_dir)
  );

  snake_body_engine #(.WRAP(1)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .init(init), .step(wif),
    .head_x(w_head_x), .head_y(w_head_y), .tail_x(w_tail_x), .tail_y(w_tail_y),
    .length(w_length), .cur_dir(w_cur_dir), .done(w_done),
    .hit_wall(w_hit_wall), .hit_self(w_hit_self), .rd_idx(w_rd_idx), .rd_dir(w_rd_dir)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  function automatic vec_t mk(input int pi, input int d, input int g, input int hx, input int hy,
                              input int tx, input int ty, input int ln, input int cd, input int w,
                              input int s, input int lat, input int r0, input int r1, input int rt);
    vec_t v;
    v.pre_init = pi; v.dir = d; v.grow = g; v.hx = hx; v.hy = hy; v.tx = tx; v.ty = ty;
    v.len = ln; v.cdir = cd; v.wall = w; v.slf = s; v.lat = lat;
    v.rd0 = r0; v.rd1 = r1; v.rdtop = rt;
    return v;
  endfunction

  task automatic check_outputs(input string tag, input vec_t v);
    chk({tag, ".head_x"}, int'(head_x), v.hx);
    chk({tag, ".head_y"}, int'(head_y), v.hy);
    chk({tag, ".tail_x"}, int'(tail_x), v.tx);
    chk({tag, ".tail_y"}, int'(tail_y), v.ty);
    chk({tag, ".length"}, int'(length), v.len);
    chk({tag, ".cur_dir"}, int'(cur_dir), v.cdir);
    chk({tag, ".hit_wall"}, int'(hit_wall), v.wall);
    chk({tag, ".hit_self"}, int'(hit_self), v.slf);
    chk({tag, ".step_ready"}, int'(sif.step_ready), (v.wall == 0 && v.slf == 0) ? 1 : 0);
    rd_idx = 4'd0;            #1 chk({tag, ".rd0"}, int'(rd_dir), v.rd0);
    rd_idx = 4'd1;            #1 chk({tag, ".rd1"}, int'(rd_dir), v.rd1);
    rd_idx = 4'(v.len - 2);   #1 chk({tag, ".rd_top"}, int'(rd_dir), v.rdtop);
    rd_idx = 4'(v.len - 1);   #1 chk({tag, ".rd_end"}, int'(rd_dir), NONE);
  endtask

  task automatic check_start(input string tag);
    chk({tag, ".done"}, int'(done), 0);
    check_outputs(tag, mk(0, 0, 0, 61, 43, 61, 45, 3, UP, 0, 0, 0, UP, UP, UP));
  endtask

  task automatic apply_init(input string tag);
    @(negedge clk);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    check_start(tag);
  endtask

  task automatic do_step(input string tag, input vec_t v);
    exp_t e;
    int   waited;
    waited = 0;
    while (sif.step_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, ".ready_before"}, int'(sif.step_ready), 1);
    if (sif.step_ready !== 1'b1) return;
    sif.step_dir   = 3'(v.dir);
    sif.step_grow  = (v.grow != 0);
    sif.step_valid = 1'b1;
    @(posedge clk);
    #1;
    // Scramble the inputs so only the accept-edge sample can matter.
    sif.step_valid = 1'b0;
    sif.step_dir   = ~3'(v.dir);
    sif.step_grow  = (v.grow == 0);
    e.v   = v;
    e.acc = cyc;
    sb.push_back(e);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (done !== 1'b1 && waited < 40);
    if (done !== 1'b1) begin
      chk({tag, ".done_timeout"}, int'(done), 1);
      sb.delete();
      return;
    end
    e = sb.pop_front();
    chk({tag, ".latency"}, cyc - e.acc, e.v.lat);
    check_outputs(tag, e.v);
    @(negedge clk);
    chk({tag, ".done_pulse"}, int'(done), 0);
  endtask

  initial begin
    int seen;
    int waited;
    sif.step_valid = 1'b0; sif.step_dir = 3'd0; sif.step_grow = 1'b0;
    wif.step_valid = 1'b0; wif.step_dir = 3'd0; wif.step_grow = 1'b0;
    rd_idx = 4'd0;
    w_rd_idx = 4'd0;

    //           pi dir g  hx  hy  tx  ty len cdir w s lat rd0 rd1 rdtop
    tbl.push_back(mk(1, RT,  0, 62, 43, 61, 44, 3, RT, 0, 0, 5, UP, RT, RT));
    tbl.push_back(mk(1, DN,  0, 61, 42, 61, 44, 3, UP, 0, 0, 5, UP, UP, UP));
    tbl.push_back(mk(0, NONE,0, 61, 41, 61, 43, 3, UP, 0, 0, 5, UP, UP, UP));
    tbl.push_back(mk(0, 6,   0, 61, 40, 61, 42, 3, UP, 0, 0, 5, UP, UP, UP));
    tbl.push_back(mk(1, UP,  1, 61, 42, 61, 45, 4, UP, 0, 0, 5, UP, UP, UP));
    tbl.push_back(mk(0, UP,  1, 61, 41, 61, 45, 5, UP, 0, 0, 6, UP, UP, UP));
    tbl.push_back(mk(0, RT,  0, 62, 41, 61, 44, 5, RT, 0, 0, 7, UP, UP, RT));
    tbl.push_back(mk(0, DN,  0, 62, 42, 61, 43, 5, DN, 0, 0, 7, UP, UP, DN));
    tbl.push_back(mk(0, LT,  0, 62, 42, 61, 43, 5, DN, 0, 1, 7, UP, UP, DN));
    tbl.push_back(mk(1, UP,  1, 61, 42, 61, 45, 4, UP, 0, 0, 5, UP, UP, UP));
    tbl.push_back(mk(0, RT,  0, 62, 42, 61, 44, 4, RT, 0, 0, 6, UP, UP, RT));
    tbl.push_back(mk(0, DN,  0, 62, 43, 61, 43, 4, DN, 0, 0, 6, UP, RT, DN));
    tbl.push_back(mk(0, LT,  0, 61, 43, 61, 42, 4, LT, 0, 0, 6, RT, DN, LT));
    tbl.push_back(mk(0, UP,  1, 61, 43, 61, 42, 4, LT, 0, 1, 6, RT, DN, LT));
    tbl.push_back(mk(1, RT,  0, 62, 43, 61, 44, 3, RT, 0, 0, 5, UP, RT, RT));
    tbl.push_back(mk(0, RT,  0, 63, 43, 61, 43, 3, RT, 0, 0, 5, RT, RT, RT));
    tbl.push_back(mk(0, RT,  0, 63, 43, 61, 43, 3, RT, 1, 0, 2, RT, RT, RT));

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_start("reset");

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].pre_init != 0) apply_init($sformatf("init%0d", i));
      do_step($sformatf("vec%0d", i), tbl[i]);
    end

    // Blocked while hit_wall: a held request must never be accepted.
    sif.step_dir = 3'(RT);
    sif.step_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    sif.step_valid = 1'b0;
    chk("blocked.done_count", seen, 0);
    chk("blocked.head_x", int'(head_x), 63);
    chk("blocked.ready", int'(sif.step_ready), 0);

    // Grow to the maximum, then a grow at MAX_LEN is a plain move.
    apply_init("init_grow");
    for (int i = 0; i < 12; i++)
      do_step($sformatf("grow%0d", i), mk(0, UP, 1, 61, 42 - i, 61, 45, 4 + i, UP, 0, 0, 5 + i, UP, UP, UP));
    do_step("grow_at_max", mk(0, UP, 1, 61, 30, 61, 44, 15, UP, 0, 0, 17, UP, UP, UP));
    do_step("full_right",  mk(0, RT, 0, 62, 30, 61, 43, 15, RT, 0, 0, 17, UP, UP, RT));
    do_step("full_down",   mk(0, DN, 0, 62, 31, 61, 42, 15, DN, 0, 0, 17, UP, UP, DN));

    // init in the middle of the body walk aborts the step without done.
    sif.step_dir = 3'(UP);
    sif.step_grow = 1'b0;
    sif.step_valid = 1'b1;
    @(posedge clk);
    #1;
    sif.step_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    check_start("abort");
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort.done_count", seen, 0);

    // Toroidal instance: walking off the right edge reappears at x=0.
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      wif.step_dir = 3'(RT);
      wif.step_grow = 1'b0;
      wif.step_valid = 1'b1;
      @(posedge clk);
      #1;
      wif.step_valid = 1'b0;
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (w_done !== 1'b1 && waited < 40);
      chk($sformatf("wrap%0d.done", s), int'(w_done), 1);
    end
    chk("wrap.head_x", int'(w_head_x), 0);
    chk("wrap.head_y", int'(w_head_y), 43);
    chk("wrap.tail_x", int'(w_tail_x), 62);
    chk("wrap.tail_y", int'(w_tail_y), 43);
    chk("wrap.hit_wall", int'(w_hit_wall), 0);
    chk("wrap.length", int'(w_length), 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
